// File: rtl/muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | muldiv_unit : iterative RV32M multiply/divide unit with regfile writeback |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_addr,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      wb_addr,
  output logic            wb_we
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [2:0]          r_funct3;
  logic [4:0]          r_rd;
  logic                r_neg_a, r_neg_b, r_bzero;
  logic [XLEN-1:0]     r_opm;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_result;
  logic [4:0]          r_wb_addr;

  logic                w_accept, w_last;
  logic                w_is_div, w_sgn_a, w_sgn_b, w_in_neg_a, w_in_neg_b;
  logic [XLEN-1:0]     w_mag_a, w_mag_b;
  logic [XLEN:0]       w_sum, w_diff;
  logic [2*XLEN-1:0]   w_acc_step, w_prod;
  logic [XLEN-1:0]     w_quo, w_rem, w_res;

  assign w_is_div   = funct3[2];
  assign w_sgn_a    = funct3[2] ? ~funct3[0] : ~(funct3[1] & funct3[0]);
  assign w_sgn_b    = funct3[2] ? ~funct3[0] : ~funct3[1];
  assign w_in_neg_a = w_sgn_a & op_a[XLEN-1];
  assign w_in_neg_b = w_sgn_b & op_b[XLEN-1];
  assign w_mag_a    = w_in_neg_a ? -op_a : op_a;
  assign w_mag_b    = w_in_neg_b ? -op_b : op_b;

  assign w_accept = start && !abort && (r_state == S_IDLE || r_state == S_FINISH);
  assign w_last   = (r_cnt == C_CNT_ONE);

  // r_acc holds {hi, lo}: {partial product, multiplier} or {remainder, quotient}
  assign w_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_opm};
  assign w_diff = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_opm};

  always_comb begin
    w_acc_step = r_acc;
    if (r_funct3[2]) begin
      if (!w_diff[XLEN]) w_acc_step = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
      else               w_acc_step = {r_acc[2*XLEN-2:0], 1'b0};
    end else begin
      if (r_acc[0]) w_acc_step = {w_sum, r_acc[XLEN-1:1]};
      else          w_acc_step = {1'b0, r_acc[2*XLEN-1:1]};
    end
  end

  assign w_prod = (r_neg_a ^ r_neg_b) ? -w_acc_step : w_acc_step;
  assign w_quo  = w_acc_step[XLEN-1:0];
  assign w_rem  = w_acc_step[2*XLEN-1:XLEN];

  // Signed overflow falls out of the magnitude path; only /0 needs an override
  always_comb begin
    w_res = '0;
    case (r_funct3)
      3'b000:                 w_res = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_res = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_res = r_bzero ? '1 : ((r_neg_a ^ r_neg_b) ? -w_quo : w_quo);
      default:                w_res = r_neg_a ? -w_rem : w_rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_RUN;
      S_RUN:    if (w_last) w_state_nxt = S_FINISH;
      S_FINISH: w_state_nxt = start ? S_RUN : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    if (abort) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_funct3  <= '0;
      r_rd      <= '0;
      r_neg_a   <= 1'b0;
      r_neg_b   <= 1'b0;
      r_bzero   <= 1'b0;
      r_opm     <= '0;
      r_acc     <= '0;
      r_result  <= '0;
      r_wb_addr <= '0;
    end else if (w_accept) begin
      r_cnt    <= C_CNT_INIT;
      r_funct3 <= funct3;
      r_rd     <= rd_addr;
      r_neg_a  <= w_in_neg_a;
      r_neg_b  <= w_in_neg_b;
      r_bzero  <= (op_b == '0);
      r_opm    <= w_is_div ? w_mag_b : w_mag_a;
      r_acc    <= {{XLEN{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
    end else if (r_state == S_RUN && !abort) begin
      r_acc <= w_acc_step;
      r_cnt <= r_cnt - C_CNT_ONE;
      if (w_last) begin
        r_result  <= w_res;
        r_wb_addr <= r_rd;
      end
    end
  end

  assign busy    = (r_state == S_RUN);
  assign done    = (r_state == S_FINISH);
  assign result  = r_result;
  assign wb_addr = r_wb_addr;
  assign wb_we   = done && (r_wb_addr != 5'd0);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_muldiv_unit : vector table, random ops vs. arithmetic model, handshake |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_muldiv_unit;

  logic        clk, rst, start, abort;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_addr;
  logic        busy, done, wb_we;
  logic [31:0] result;
  logic [4:0]  wb_addr;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .rd_addr(rd_addr), .abort(abort), .busy(busy), .done(done), .result(result),
    .wb_addr(wb_addr), .wb_we(wb_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // RV32M semantics straight from the ISA rules, using wide native arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    int          ia, ib;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    ia = $signed(a);
    ib = $signed(b);
    r  = '0;
    case (f)
      3'd0: begin p = 64'(sa * sb); r = p[31:0]; end
      3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
      3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = 32'(ia / ib);
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
        else r = 32'(ia % ib);
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_addr = rd;
    step();
    start = 1'b0;
    funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom; rd_addr = 5'($urandom);
  endtask

  task automatic wait_done(input int from, output int cyc);
    int c;
    c = from;
    while (c < 80 && done !== 1'b1) begin
      step();
      c++;
    end
    cyc = (done === 1'b1) ? c : -1;
  endtask

  task automatic count_dones(input int n, output int seen);
    seen = 0;
    for (int k = 0; k < n; k++) begin
      if (done === 1'b1) seen++;
      step();
    end
  endtask

  task automatic do_op(input string nm, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp);
    int bad;
    launch(f, a, b, rd);
    bad = 0;
    for (int k = 1; k <= 32; k++) begin
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      step();
    end
    chk({nm, "_busy_window"}, 32'(bad), 32'd0);
    chk({nm, "_done"}, {31'd0, done}, 32'd1);
    chk({nm, "_result"}, result, exp);
    chk({nm, "_wb_addr"}, {27'd0, wb_addr}, {27'd0, rd});
    chk({nm, "_wb_we"}, {31'd0, wb_we}, {31'd0, rd != 5'd0});
    step();
    chk({nm, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int   cyc, seen;
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    logic [4:0]  rrd;

    rst = 1'b0; start = 1'b0; abort = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_addr = '0;

    tbl[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
    tbl[1]  = '{3'b001, 32'h8000_0000,  32'h8000_0000, 5'd6,  32'h4000_0000};
    tbl[2]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE};
    tbl[3]  = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF};
    tbl[4]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFD};
    tbl[5]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFF};
    tbl[6]  = '{3'b101, 32'd5,          32'd0,         5'd11, 32'hFFFF_FFFF};
    tbl[7]  = '{3'b111, 32'd5,          32'd0,         5'd12, 32'd5};
    tbl[8]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32'h8000_0000};
    tbl[9]  = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 32'd0};
    tbl[10] = '{3'b100, 32'hFFFF_FFF9,  32'd0,         5'd15, 32'hFFFF_FFFF};
    tbl[11] = '{3'b110, 32'hFFFF_FFF9,  32'd0,         5'd16, 32'hFFFF_FFF9};
    tbl[12] = '{3'b011, 32'd3,          32'd4,         5'd0,  32'd0};

    step(); step();
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_wb_we", {31'd0, wb_we}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_wb_addr", {27'd0, wb_addr}, 32'd0);
    rst = 1'b1;
    step();

    for (int i = 0; i < 13; i++)
      do_op($sformatf("vec%0d", i), tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].exp);

    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom);
      case ($urandom_range(0, 5))
        0:       ra = 32'h8000_0000;
        1:       ra = $urandom_range(0, 20);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = $urandom_range(1, 9);
        default: rb = $urandom;
      endcase
      rrd = 5'($urandom);
      do_op($sformatf("rand%0d_f%0d", i, rf), rf, ra, rb, rrd, ref_model(rf, ra, rb));
    end

    // start pulsed mid-operation must be dropped
    launch(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5);
    step(); step(); step(); step();
    start = 1'b1; funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; rd_addr = 5'd9;
    step();
    start = 1'b0;
    wait_done(6, cyc);
    chk("busy_start_latency", 32'(cyc), 32'd33);
    chk("busy_start_result", result, 32'hFFFF_FFEB);
    chk("busy_start_wb_addr", {27'd0, wb_addr}, 32'd5);
    step();
    chk("busy_start_not_queued", {30'd0, busy, done}, 32'd0);

    // back-to-back: start held in FINISH
    launch(3'b101, 32'd100, 32'd7, 5'd3);
    wait_done(1, cyc);
    chk("b2b_first_latency", 32'(cyc), 32'd33);
    chk("b2b_first_result", result, 32'd14);
    start = 1'b1; funct3 = 3'b111; op_a = 32'd100; op_b = 32'd7; rd_addr = 5'd4;
    step();
    start = 1'b0;
    chk("b2b_second_busy", {31'd0, busy}, 32'd1);
    wait_done(1, cyc);
    chk("b2b_second_latency", 32'(cyc), 32'd33);
    chk("b2b_second_result", result, 32'd2);
    chk("b2b_second_wb_addr", {27'd0, wb_addr}, 32'd4);
    step();

    // abort at cycle 10
    launch(3'b000, 32'd9, 32'd9, 5'd20);
    for (int k = 1; k < 10; k++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    count_dones(45, seen);
    chk("abort_no_done", 32'(seen), 32'd0);
    chk("abort_result_hold", result, 32'd2);
    chk("abort_wb_addr_hold", {27'd0, wb_addr}, 32'd4);

    // abort and start together: abort wins
    start = 1'b1; abort = 1'b1; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd3; rd_addr = 5'd21;
    step();
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", {31'd0, busy}, 32'd0);
    count_dones(45, seen);
    chk("abort_start_no_done", 32'(seen), 32'd0);

    // asynchronous reset mid-operation
    launch(3'b000, 32'd11, 32'd13, 5'd22);
    for (int k = 1; k < 10; k++) step();
    #1 rst = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    chk("rst_mid_wb_we", {31'd0, wb_we}, 32'd0);
    chk("rst_mid_result", result, 32'd0);
    step();
    rst = 1'b1;
    count_dones(45, seen);
    chk("rst_mid_no_done", 32'(seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
